// File: rtl/rx_buf_alloc.sv
// ---------------------------------------------------------------------------
// rx_buf_alloc
//   Circular allocator for the receive data RAM. Grants dword-aligned,
//   contiguous regions to the frame writer and reclaims them in allocation
//   order as descriptors retire. When a request does not fit in the space
//   left before the end of the RAM, but does fit at the bottom, the unusable
//   tail is booked as "skip" bytes. Those bytes are held until the release
//   pointer reaches them.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   alloc_req_*      allocation request (len in bytes, valid/ready)
//   alloc_addr/len   granted byte address / rounded length
//   alloc_err        request larger than the whole RAM, never grantable
//   alloc_valid/ready grant handshake
//   free_len/valid/ready release of the oldest outstanding buffer
//   bytes_used       allocated bytes plus held skip bytes
//   free_err         sticky: a release exceeded the outstanding allocation
// ---------------------------------------------------------------------------
module rx_buf_alloc #(
    parameter int RAM_BYTES = 32768,
    parameter int ADDR_BITS = 16,
    parameter int LEN_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_BITS-1:0]  alloc_req_len,
    input  logic                 alloc_req_valid,
    output logic                 alloc_req_ready,
    output logic [ADDR_BITS-1:0] alloc_addr,
    output logic [LEN_BITS-1:0]  alloc_len,
    output logic                 alloc_err,
    output logic                 alloc_valid,
    input  logic                 alloc_ready,
    input  logic [LEN_BITS-1:0]  free_len,
    input  logic                 free_valid,
    output logic                 free_ready,
    output logic [ADDR_BITS:0]   bytes_used,
    output logic                 free_err
);

    // Common compare width, wide enough for lengths, sizes and sums.
    localparam int CW = ((LEN_BITS > ADDR_BITS) ? LEN_BITS : ADDR_BITS) + 2;
    localparam logic [CW-1:0]        RAM_C    = CW'(RAM_BYTES);
    localparam logic [ADDR_BITS-1:0] PTR_MASK = ADDR_BITS'(RAM_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] head_q, head_d;
    logic [ADDR_BITS-1:0] tail_q, tail_d;
    logic [ADDR_BITS:0]   used_q, used_d;
    logic [ADDR_BITS-1:0] skip_q, skip_d;
    logic                 wrap_q, wrap_d;
    logic [LEN_BITS:0]    rlen_q, rlen_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic                 err_q, err_d;
    logic                 ferr_q, ferr_d;

    logic [CW-1:0]        rlen_c, free_c, head_c, tail_c, used_c, skip_c;
    logic [CW-1:0]        avail_c, rel_used, grant_used;
    logic [ADDR_BITS-1:0] tail_adv, grant_addr;
    logic                 take_free, do_grant, room_ok;

    function automatic logic [LEN_BITS:0] round4(input logic [LEN_BITS-1:0] l);
        logic [LEN_BITS:0] r;
        r      = {1'b0, l} + (LEN_BITS+1)'(3);
        r[1:0] = 2'b00;
        return r;
    endfunction

    assign alloc_req_ready = (state_q == S_IDLE) && !free_valid;
    assign free_ready      = (state_q == S_IDLE) || (state_q == S_WAIT);
    assign take_free       = free_valid && free_ready;
    assign alloc_valid     = (state_q == S_GRANT);
    assign alloc_addr      = addr_q;
    assign alloc_len       = len_q;
    assign alloc_err       = err_q;
    assign bytes_used      = used_q;
    assign free_err        = ferr_q;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        used_d     = used_q;
        skip_d     = skip_q;
        wrap_d     = wrap_q;
        rlen_d     = rlen_q;
        addr_d     = addr_q;
        len_d      = len_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
        do_grant   = 1'b0;
        grant_addr = '0;

        rlen_c     = CW'(rlen_q);
        free_c     = CW'(round4(free_len));
        head_c     = CW'(head_q);
        tail_c     = CW'(tail_q);
        used_c     = CW'(used_q);
        skip_c     = CW'(skip_q);
        // Skip bytes are not releasable by descriptors; exclude them.
        avail_c    = used_c - (wrap_q ? skip_c : '0);
        tail_adv   = ADDR_BITS'(tail_c + free_c) & PTR_MASK;
        rel_used   = used_c - free_c;
        grant_used = used_c + rlen_c;
        // Total free space; this also stops a full ring with head==tail
        // from looking empty to the head>=tail rules below.
        room_ok    = (rlen_c <= RAM_C - used_c);

        case (state_q)
            S_IDLE: begin
                if (!free_valid && alloc_req_valid) begin
                    rlen_d  = round4(alloc_req_len);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!free_valid) begin
                    if (rlen_c > RAM_C) begin
                        err_d   = 1'b1;
                        state_d = S_GRANT;
                    end else if (!room_ok) begin
                        state_d = S_WAIT;
                    end else if (used_q == '0) begin
                        // Empty ring: rebase so the largest contiguous
                        // region is available.
                        do_grant = 1'b1;
                        tail_d   = '0;
                    end else if (head_q >= tail_q && rlen_c <= RAM_C - head_c) begin
                        do_grant   = 1'b1;
                        grant_addr = head_q;
                    end else if (head_q >= tail_q && rlen_c <= tail_c) begin
                        // Wrap: book the tail end of the RAM as skip bytes.
                        do_grant   = 1'b1;
                        skip_d     = ADDR_BITS'(RAM_C - head_c);
                        wrap_d     = 1'b1;
                        grant_used = used_c + rlen_c + (RAM_C - head_c);
                    end else if (head_q < tail_q && rlen_c <= tail_c - head_c) begin
                        do_grant   = 1'b1;
                        grant_addr = head_q;
                    end
                end
            end
            S_GRANT: begin
                if (alloc_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_grant) begin
            addr_d  = grant_addr;
            len_d   = LEN_BITS'(rlen_q);
            head_d  = ADDR_BITS'(CW'(grant_addr) + rlen_c) & PTR_MASK;
            used_d  = (ADDR_BITS+1)'(grant_used);
            state_d = S_GRANT;
        end

        if (take_free) begin
            if (free_c > avail_c) begin
                ferr_d = 1'b1;
            end else begin
                tail_d = tail_adv;
                // Tail reached the skipped region: drop it and jump to 0.
                if (wrap_q && CW'(tail_adv) == RAM_C - skip_c) begin
                    tail_d   = '0;
                    rel_used = rel_used - skip_c;
                    wrap_d   = 1'b0;
                end
                used_d = (ADDR_BITS+1)'(rel_used);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            used_q  <= '0;
            skip_q  <= '0;
            wrap_q  <= 1'b0;
            rlen_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            used_q  <= used_d;
            skip_q  <= skip_d;
            wrap_q  <= wrap_d;
            rlen_q  <= rlen_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_rx_buf_alloc.sv
// ---------------------------------------------------------------------------
// tb_rx_buf_alloc
//   Directed bench: instance 0 uses a 256-byte RAM, instance 1 the default
//   32 KiB RAM. Expected values are hand-derived from the allocator rules.
// ---------------------------------------------------------------------------
module tb_rx_buf_alloc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] req_len   [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [15:0] a_addr    [2];
    logic [15:0] a_len     [2];
    logic        a_err     [2];
    logic        a_valid   [2];
    logic        a_ready   [2];
    logic [15:0] f_len     [2];
    logic        f_valid   [2];
    logic        f_ready   [2];
    logic [16:0] used      [2];
    logic        f_err     [2];

    int vec_cnt = 0;
    int err_cnt = 0;

    rx_buf_alloc #(.RAM_BYTES(256), .ADDR_BITS(16), .LEN_BITS(16)) u_small (
        .clk(clk), .rst(rst),
        .alloc_req_len(req_len[0]), .alloc_req_valid(req_valid[0]),
        .alloc_req_ready(req_ready[0]),
        .alloc_addr(a_addr[0]), .alloc_len(a_len[0]), .alloc_err(a_err[0]),
        .alloc_valid(a_valid[0]), .alloc_ready(a_ready[0]),
        .free_len(f_len[0]), .free_valid(f_valid[0]), .free_ready(f_ready[0]),
        .bytes_used(used[0]), .free_err(f_err[0])
    );

    rx_buf_alloc #(.RAM_BYTES(32768), .ADDR_BITS(16), .LEN_BITS(16)) u_big (
        .clk(clk), .rst(rst),
        .alloc_req_len(req_len[1]), .alloc_req_valid(req_valid[1]),
        .alloc_req_ready(req_ready[1]),
        .alloc_addr(a_addr[1]), .alloc_len(a_len[1]), .alloc_err(a_err[1]),
        .alloc_valid(a_valid[1]), .alloc_ready(a_ready[1]),
        .free_len(f_len[1]), .free_valid(f_valid[1]), .free_ready(f_ready[1]),
        .bytes_used(used[1]), .free_err(f_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Present a request and return just after the accepting edge.
    task automatic send_req(input int d, input logic [15:0] len);
        int n;
        n = 0;
        @(negedge clk);
        req_len[d]   = len;
        req_valid[d] = 1'b1;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) check($sformatf("dut%0d req accept", d), 32'(req_ready[d]), 1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask

    // Count negedges after acceptance until alloc_valid (bounded).
    task automatic wait_grant(input int d, input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_valid[d] && lat < 100);
        check({tag, " alloc_valid"}, 32'(a_valid[d]), 1);
    endtask

    task automatic take_grant(input int d, input string tag);
        @(negedge clk);
        a_ready[d] = 1'b1;
        @(posedge clk);
        #1 a_ready[d] = 1'b0;
        @(negedge clk);
        check({tag, " valid dropped"}, 32'(a_valid[d]), 0);
    endtask

    task automatic do_alloc(input int d, input string tag, input logic [15:0] len,
                            input int eaddr, input int elen, input int eused);
        int lat;
        send_req(d, len);
        wait_grant(d, tag, lat);
        check({tag, " addr"}, 32'(a_addr[d]), eaddr);
        check({tag, " len"},  32'(a_len[d]),  elen);
        check({tag, " err"},  32'(a_err[d]),  0);
        check({tag, " used"}, 32'(used[d]),   eused);
        take_grant(d, tag);
    endtask

    task automatic do_free(input int d, input string tag, input logic [15:0] len, input int eused);
        @(negedge clk);
        f_len[d]   = len;
        f_valid[d] = 1'b1;
        #1 check({tag, " free_ready"}, 32'(f_ready[d]), 1);
        @(posedge clk);
        #1 f_valid[d] = 1'b0;
        @(negedge clk);
        check({tag, " used"}, 32'(used[d]), eused);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_len[i] = '0; req_valid[i] = 1'b0; a_ready[i] = 1'b0;
            f_len[i] = '0; f_valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d used", i),      32'(used[i]),      0);
            check($sformatf("rst%0d valid", i),     32'(a_valid[i]),   0);
            check($sformatf("rst%0d err", i),       32'(a_err[i]),     0);
            check($sformatf("rst%0d free_err", i),  32'(f_err[i]),     0);
            check($sformatf("rst%0d addr", i),      32'(a_addr[i]),    0);
            check($sformatf("rst%0d len", i),       32'(a_len[i]),     0);
            check($sformatf("rst%0d req_ready", i), 32'(req_ready[i]), 1);
            check($sformatf("rst%0d free_ready", i),32'(f_ready[i]),   1);
        end

        // 1: 61 bytes rounds to 64 at address 0, two cycles after accept.
        send_req(0, 16'd61);
        wait_grant(0, "t1", lat);
        check("t1 latency", 32'(lat), 2);
        check("t1 addr", 32'(a_addr[0]), 0);
        check("t1 len",  32'(a_len[0]),  64);
        check("t1 used", 32'(used[0]),   64);
        take_grant(0, "t1");
        do_free(0, "t1 free61", 16'd61, 0);

        // Release has priority: request not ready while free_valid is high.
        @(negedge clk);
        f_len[0] = 16'd0; f_valid[0] = 1'b1;
        #1 check("prio req_ready", 32'(req_ready[0]), 0);
        @(posedge clk);
        #1 f_valid[0] = 1'b0;

        // 2: empty ring rebases to address 0.
        do_alloc(0, "t2a", 16'd200, 0, 200, 200);
        do_free(0, "t2 free200", 16'd200, 0);
        do_alloc(0, "t2b", 16'd100, 0, 100, 100);
        do_free(0, "t2 free100", 16'd100, 0);

        // 3: wrap with 16 skip bytes, reclaimed when tail reaches them.
        do_alloc(0, "t3a", 16'd200, 0,   200, 200);
        do_alloc(0, "t3b", 16'd40,  200, 40,  240);
        do_free(0, "t3 free200", 16'd200, 40);
        do_alloc(0, "t3 wrap", 16'd48, 0, 48, 104);
        do_free(0, "t3 free40", 16'd40, 48);
        // tail must now be 0: 200 fits contiguously at head=48.
        do_alloc(0, "t3c", 16'd200, 48, 200, 248);
        do_free(0, "t3 free48", 16'd48, 200);
        do_free(0, "t3 free200b", 16'd200, 0);

        // 4: stall in S_WAIT until a release makes room.
        do_alloc(0, "t4a", 16'd248, 0, 248, 248);
        send_req(0, 16'd16);
        repeat (5) @(negedge clk);
        check("t4 stalled valid", 32'(a_valid[0]), 0);
        check("t4 stalled used",  32'(used[0]),    248);
        do_free(0, "t4 free248", 16'd248, 0);
        wait_grant(0, "t4b", lat);
        check("t4b latency", 32'(lat), 1);
        check("t4b addr", 32'(a_addr[0]), 0);
        check("t4b used", 32'(used[0]),   16);
        take_grant(0, "t4b");
        do_free(0, "t4 free16", 16'd16, 0);

        // 5: oversized request on the 32 KiB instance, then a bogus release.
        send_req(1, 16'd40000);
        wait_grant(1, "t5", lat);
        check("t5 latency", 32'(lat), 2);
        check("t5 err",  32'(a_err[1]), 1);
        check("t5 used", 32'(used[1]),  0);
        take_grant(1, "t5");
        check("t5 err dropped", 32'(a_err[1]), 0);
        do_free(1, "t5 free8", 16'd8, 0);
        check("t5 free_err", 32'(f_err[1]), 1);
        do_alloc(1, "t5 full", 16'd32768, 0, 32768, 32768);
        do_free(1, "t5 free all", 16'd32768, 0);
        check("t5 free_err sticky", 32'(f_err[1]), 1);

        // 6: reset while a grant is pending.
        do_free(0, "t6 bogus", 16'd8, 0);
        check("t6 free_err", 32'(f_err[0]), 1);
        do_alloc(0, "t6a", 16'd100, 0, 100, 100);
        send_req(0, 16'd4);
        wait_grant(0, "t6b", lat);
        check("t6b addr", 32'(a_addr[0]), 100);
        check("t6b used", 32'(used[0]),   104);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6 rst valid",    32'(a_valid[0]), 0);
        check("t6 rst used",     32'(used[0]),    0);
        check("t6 rst free_err", 32'(f_err[0]),   0);
        check("t6 rst addr",     32'(a_addr[0]),  0);
        @(negedge clk);
        rst = 1'b0;
        do_alloc(0, "t6c", 16'd4, 0, 4, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", vec_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rx_buf_alloc.md
Name: rx_buf_alloc

Overview:
Circular allocator and scheduler for the receive data RAM. It grants dword-aligned, contiguous buffer regions to the frame writer and reclaims them in allocation order as descriptors are retired. Unlike flat byte-count accounting, it handles end-of-RAM wrap by skipping the unusable tail and holding those bytes until the release pointer reaches them. It sits between the receive frame path (allocation requests) and the descriptor-retire path (releases).

Parameters:
RAM_BYTES, 32768, data RAM size in bytes; must be a power of 2 and a multiple of 4.
ADDR_BITS, 16, width of byte addresses; 2^ADDR_BITS >= RAM_BYTES.
LEN_BITS, 16, width of length fields.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
alloc_req_len  in  LEN_BITS  requested bytes
alloc_req_valid  in  1  request valid
alloc_req_ready  out  1  request accepted when valid&&ready
alloc_addr  out  ADDR_BITS  granted byte address (dword aligned)
alloc_len  out  LEN_BITS  granted length, rounded up to a multiple of 4
alloc_err  out  1  request can never fit; addr/len invalid
alloc_valid  out  1  grant valid
alloc_ready  in  1  grant consumed
free_len  in  LEN_BITS  bytes released by the oldest outstanding buffer
free_valid  in  1  release valid
free_ready  out  1  release accepted
bytes_used  out  ADDR_BITS+1  allocated bytes plus held skip bytes
free_err  out  1  sticky: release exceeded outstanding allocation

Behaviour:
- Reset: state=S_IDLE; head=tail=0; bytes_used=0; wrap_pend=0; skip=0; alloc_valid=0; alloc_err=0; free_err=0; alloc_addr=0; alloc_len=0.
- rlen = (len+3) & ~3, computed at LEN_BITS+1 width. Pointer arithmetic is modulo RAM_BYTES. head = next allocation address; tail = oldest outstanding address.
- alloc_req_ready = (state==S_IDLE && !free_valid). free_ready = (state==S_IDLE || state==S_WAIT). Both are combinational.
- S_IDLE:
  - If free_valid: apply the release and stay in S_IDLE. Releases take priority over allocation requests.
  - Else if alloc_req_valid: latch rlen and go to S_WAIT.
- S_WAIT:
  - If free_valid: apply the release and stay in S_WAIT. Fit is re-evaluated on the next cycle.
  - Else if rlen > RAM_BYTES: go to S_GRANT with alloc_err=1. Pointers are unchanged.
  - Else evaluate fit (first matching rule applies):
    - bytes_used==0: head=tail=0, then grant at 0.
    - head>=tail and rlen <= RAM_BYTES-head: grant at head.
    - head>=tail and rlen <= tail: wrap. skip = RAM_BYTES-head; wrap_pend=1; grant at 0; bytes_used += skip.
    - head<tail and rlen <= tail-head: grant at head.
    - Otherwise stay in S_WAIT. This stalls the request with no timeout.
  - On grant: alloc_addr = grant address; alloc_len = rlen; head = grant address + rlen (mod); bytes_used += rlen; go to S_GRANT.
  - rlen==0: grant at head with no pointer change.
- S_GRANT: alloc_valid=1 and outputs held stable. Go to S_IDLE on alloc_ready, then drop alloc_valid and alloc_err.
- Release, in a free_valid && free_ready cycle:
  - If rlen > bytes_used - (wrap_pend ? skip : 0): set free_err (sticky until rst) and ignore the release.
  - Else: tail += rlen (mod); bytes_used -= rlen.
  - If wrap_pend and the new tail == RAM_BYTES-skip: tail=0; bytes_used -= skip; wrap_pend=0. This update occurs in the same cycle.
- Only one wrap can be outstanding, because head cannot pass tail.
- Minimum latency: request accepted at cycle T, alloc_valid at T+2.
- rst asserted mid-operation: all state returns to reset values immediately. Any in-flight grant is dropped.

Test Plan:
1. RAM_BYTES=256. Request 61 -> alloc_addr=0, alloc_len=64, alloc_valid 2 cycles after acceptance, bytes_used=64.
2. RAM_BYTES=256. Allocate 200, free 200, allocate 100 -> grant at 0 (used==0 rebase), bytes_used=100.
3. RAM_BYTES=256. Allocate 200 and 40; free 200; request 48 -> wrap. alloc_addr=0, skip=16, bytes_used=104. Free 40 -> tail=0, bytes_used=48, wrap_pend=0.
4. RAM_BYTES=256. Allocate 248; request 16 -> stays in S_WAIT with alloc_valid=0. Free 248 -> next cycle grants addr=0 (used==0 rebase), bytes_used=16.
5. Request 40000 with RAM_BYTES=32768 -> alloc_valid with alloc_err=1, bytes_used unchanged. Free 8 with nothing outstanding -> free_err=1, tail=0.
6. Assert rst while alloc_valid=1 -> next cycle alloc_valid=0, bytes_used=0, free_err=0; request 4 afterwards -> alloc_addr=0.
